// File: rtl/ddr3_arb_pkg.sv
// Shared types, field widths and the round-robin pick function for the ddr3_core port arbiter.
package ddr3_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    localparam int STRB_W    = 16;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 128;
    localparam int MAX_PORTS = 8;
    localparam int CNT_W     = 4;

    // Unused request bits must be zero, so scanning modulo MAX_PORTS wraps correctly for any port count.
    function automatic logic [2:0] rr_pick(input logic [MAX_PORTS-1:0] valid, input logic [2:0] last);
        logic [2:0] idx;
        rr_pick = last;
        for (int i = MAX_PORTS; i >= 1; i--) begin
            idx = last + 3'(i);
            if (valid[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/ddr3_arb_rr.sv
// Round-robin pick: first set request after last_i, wrapping; purely combinational, no backpressure.
module ddr3_arb_rr
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    last_i,
    output logic                 any_o,
    output logic [PORT_W-1:0]    grant_o
);

    logic [MAX_PORTS-1:0] req_ext;

    always_comb begin
        req_ext                  = '0;
        req_ext[NUM_PORTS-1:0]   = req_i;
        grant_o                  = PORT_W'(rr_pick(req_ext, 3'(last_i)));
    end

    assign any_o = |req_i;

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares the ddr3_core request port among NUM_PORTS requesters; request reaches outport 1 cycle after it is seen,
// held until outport_accept_i, then one idle bubble; ports at their outstanding limit are skipped.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int PORT_W          = 2,
    parameter int ID_W            = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_PORTS*STRB_W-1:0] inport_wr_i,
    input  logic [NUM_PORTS-1:0]        inport_rd_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] inport_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0] inport_write_data_i,
    input  logic [NUM_PORTS*ID_W-1:0]   inport_req_id_i,
    output logic [NUM_PORTS-1:0]        inport_accept_o,
    output logic [NUM_PORTS-1:0]        inport_ack_o,
    output logic [NUM_PORTS-1:0]        inport_error_o,
    output logic [NUM_PORTS*ID_W-1:0]   inport_resp_id_o,
    output logic [DATA_W-1:0]           inport_read_data_o,
    output logic [STRB_W-1:0]           outport_wr_o,
    output logic                        outport_rd_o,
    output logic [ADDR_W-1:0]           outport_addr_o,
    output logic [DATA_W-1:0]           outport_write_data_o,
    output logic [ID_W-1:0]             outport_req_id_o,
    input  logic                        outport_accept_i,
    input  logic                        outport_ack_i,
    input  logic                        outport_error_i,
    input  logic [ID_W-1:0]             outport_resp_id_i,
    input  logic [DATA_W-1:0]           outport_read_data_i,
    output logic                        unexpected_ack_o
);

    arb_state_t           state_q, state_d;
    logic [PORT_W-1:0]    grant_q, grant_d;
    logic [PORT_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
    logic                 unexp_q, unexp_d;

    logic [NUM_PORTS-1:0] valid, eligible, inc, dec;
    logic                 any_elig, take;
    logic [PORT_W-1:0]    rr_grant;
    logic [PORT_W-1:0]    ack_port;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            valid[p]    = (|inport_wr_i[p*STRB_W +: STRB_W]) | inport_rd_i[p];
            eligible[p] = valid[p] && (cnt_q[p] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    ddr3_arb_rr #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr (
        .req_i   (eligible),
        .last_i  (last_grant_q),
        .any_o   (any_elig),
        .grant_o (rr_grant)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        take         = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_elig) begin
                    grant_d = rr_grant;
                    state_d = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (outport_accept_i) begin
                    take         = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = ARB_IDLE;
                end else if (!valid[grant_q]) begin
                    // Requester withdrew without being accepted: abandon the grant, nothing is counted.
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        outport_wr_o         = '0;
        outport_rd_o         = 1'b0;
        outport_addr_o       = '0;
        outport_write_data_o = '0;
        outport_req_id_o     = '0;
        if (state_q == ARB_HOLD) begin
            outport_wr_o         = inport_wr_i[grant_q*STRB_W +: STRB_W];
            outport_rd_o         = inport_rd_i[grant_q];
            outport_addr_o       = inport_addr_i[grant_q*ADDR_W +: ADDR_W];
            outport_write_data_o = inport_write_data_i[grant_q*DATA_W +: DATA_W];
            outport_req_id_o     = {grant_q, inport_req_id_i[grant_q*ID_W +: ID_W-PORT_W]};
        end
    end

    assign ack_port = outport_resp_id_i[ID_W-1 -: PORT_W];

    always_comb begin
        inport_accept_o    = '0;
        inport_ack_o       = '0;
        inport_error_o     = '0;
        inport_resp_id_o   = '0;
        inport_read_data_o = outport_ack_i ? outport_read_data_i : '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            inport_accept_o[p] = (state_q == ARB_HOLD) && (grant_q == PORT_W'(p)) && outport_accept_i;
            inport_ack_o[p]    = outport_ack_i && (ack_port == PORT_W'(p));
            inport_error_o[p]  = inport_ack_o[p] && outport_error_i;
            if (inport_ack_o[p]) begin
                inport_resp_id_o[p*ID_W +: ID_W] = {{PORT_W{1'b0}}, outport_resp_id_i[ID_W-PORT_W-1:0]};
            end
        end
    end

    // A same-cycle accept and ack on one port cancel; an ack with nothing outstanding only raises the flag.
    always_comb begin
        unexp_d = unexp_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            inc[p]   = take && (grant_q == PORT_W'(p));
            dec[p]   = inport_ack_o[p];
            cnt_d[p] = cnt_q[p];
            if (inc[p] && !dec[p]) begin
                cnt_d[p] = cnt_q[p] + 1'b1;
            end else if (dec[p] && !inc[p]) begin
                if (cnt_q[p] == '0) begin
                    unexp_d = 1'b1;
                end else begin
                    cnt_d[p] = cnt_q[p] - 1'b1;
                end
            end
        end
    end

    assign unexpected_ack_o = unexp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
            unexp_q      <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            unexp_q      <= unexp_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: the bench plays both the requesters and ddr3_core.
module tb_ddr3_port_arbiter;

    localparam int NP = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NP*16-1:0]    in_wr;
    logic [NP-1:0]       in_rd;
    logic [NP*32-1:0]    in_addr;
    logic [NP*128-1:0]   in_wdata;
    logic [NP*16-1:0]    in_id;
    logic [NP-1:0]       in_accept, in_ack, in_err;
    logic [NP*16-1:0]    in_resp_id;
    logic [127:0]        in_rdata;
    logic [15:0]         out_wr;
    logic                out_rd;
    logic [31:0]         out_addr;
    logic [127:0]        out_wdata;
    logic [15:0]         out_id;
    logic                out_accept, out_ack, out_err;
    logic [15:0]         out_resp_id;
    logic [127:0]        out_rdata;
    logic                unexp;

    int errors = 0;
    int checks = 0;

    logic [15:0]  cap_id, cap_wr;
    logic         cap_rd;
    logic [31:0]  cap_addr;
    logic [127:0] cap_wdata;

    always #5 clk = ~clk;

    ddr3_port_arbiter dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .inport_wr_i          (in_wr),
        .inport_rd_i          (in_rd),
        .inport_addr_i        (in_addr),
        .inport_write_data_i  (in_wdata),
        .inport_req_id_i      (in_id),
        .inport_accept_o      (in_accept),
        .inport_ack_o         (in_ack),
        .inport_error_o       (in_err),
        .inport_resp_id_o     (in_resp_id),
        .inport_read_data_o   (in_rdata),
        .outport_wr_o         (out_wr),
        .outport_rd_o         (out_rd),
        .outport_addr_o       (out_addr),
        .outport_write_data_o (out_wdata),
        .outport_req_id_o     (out_id),
        .outport_accept_i     (out_accept),
        .outport_ack_i        (out_ack),
        .outport_error_i      (out_err),
        .outport_resp_id_i    (out_resp_id),
        .outport_read_data_i  (out_rdata),
        .unexpected_ack_o     (unexp)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_all();
        in_wr       = '0;
        in_rd       = '0;
        in_addr     = '0;
        in_wdata    = '0;
        in_id       = '0;
        out_accept  = 1'b0;
        out_ack     = 1'b0;
        out_err     = 1'b0;
        out_resp_id = '0;
        out_rdata   = '0;
    endtask

    task automatic set_port(input int p, input logic [15:0] wr, input logic rd, input logic [31:0] addr,
                            input logic [127:0] data, input logic [15:0] id);
        in_wr[p*16 +: 16]     = wr;
        in_rd[p]              = rd;
        in_addr[p*32 +: 32]   = addr;
        in_wdata[p*128 +: 128] = data;
        in_id[p*16 +: 16]     = id;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // Presents one request, waits (bounded) for its accept, captures the outport view, then withdraws it.
    task automatic send_req(input int p, input logic [15:0] wr, input logic rd, input logic [31:0] addr,
                            input logic [127:0] data, input logic [15:0] id, output logic ok, output int lat);
        set_port(p, wr, rd, addr, data, id);
        out_accept = 1'b1;
        ok  = 1'b0;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (in_accept[p]) begin
                ok        = 1'b1;
                lat       = c;
                cap_id    = out_id;
                cap_wr    = out_wr;
                cap_rd    = out_rd;
                cap_addr  = out_addr;
                cap_wdata = out_wdata;
                break;
            end
        end
        if (ok) tick();
        set_port(p, 16'h0, 1'b0, 32'h0, 128'h0, 16'h0);
    endtask

    task automatic ack_on(input logic [15:0] id, input logic err, input logic [127:0] rdata);
        out_ack     = 1'b1;
        out_resp_id = id;
        out_err     = err;
        out_rdata   = rdata;
        #1;
    endtask

    task automatic ack_off();
        tick();
        out_ack     = 1'b0;
        out_err     = 1'b0;
        out_resp_id = '0;
        out_rdata   = '0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        out_accept = 1'b1;
        #3;
        checks++; if (out_wr !== 16'h0) begin errors++; $display("FAIL reset_wr: got %h want 0000", out_wr); end
        checks++; if (out_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", out_rd); end
        checks++; if (out_id !== 16'h0) begin errors++; $display("FAIL reset_req_id: got %h want 0000", out_id); end
        checks++; if (in_accept !== 4'b0) begin errors++; $display("FAIL reset_accept: got %b want 0000", in_accept); end
        checks++; if (in_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b want 0000", in_ack); end
        checks++; if (unexp !== 1'b0) begin errors++; $display("FAIL reset_unexp: got %b want 0", unexp); end
        do_reset();
    endtask

    task automatic test_port0_rw();
        logic ok;
        int   lat;
        logic [127:0] d;
        d = 128'hffeeddccbbaa99887766554433221100;
        do_reset();
        send_req(0, 16'hFFFF, 1'b0, 32'h0, d, 16'h0001, ok, lat);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t1_wr_accept: got %b want 1", ok); end
        checks++; if (lat != 1) begin errors++; $display("FAIL t1_latency: got %0d want 1", lat); end
        checks++; if (cap_wr !== 16'hFFFF) begin errors++; $display("FAIL t1_out_wr: got %h want ffff", cap_wr); end
        checks++; if (cap_wdata !== d) begin errors++; $display("FAIL t1_out_wdata: got %h want %h", cap_wdata, d); end
        checks++; if (cap_id !== 16'h0001) begin errors++; $display("FAIL t1_out_id: got %h want 0001", cap_id); end
        checks++; if (out_wr !== 16'h0) begin errors++; $display("FAIL t1_idle_bubble: got %h want 0000", out_wr); end
        ack_on(16'h0001, 1'b0, 128'h0);
        checks++; if (in_ack !== 4'b0001) begin errors++; $display("FAIL t1_wr_ack: got %b want 0001", in_ack); end
        ack_off();
        send_req(0, 16'h0, 1'b1, 32'h0, 128'h0, 16'h0002, ok, lat);
        checks++; if (ok !== 1'b1 || cap_rd !== 1'b1) begin errors++; $display("FAIL t1_rd_issue: got ok=%b rd=%b want 1 1", ok, cap_rd); end
        checks++; if (cap_id !== 16'h0002) begin errors++; $display("FAIL t1_rd_id: got %h want 0002", cap_id); end
        ack_on(16'h0002, 1'b0, d);
        checks++; if (in_ack !== 4'b0001) begin errors++; $display("FAIL t1_rd_ack: got %b want 0001", in_ack); end
        checks++; if (in_rdata !== d) begin errors++; $display("FAIL t1_rdata: got %h want %h", in_rdata, d); end
        checks++; if (in_err !== 4'b0) begin errors++; $display("FAIL t1_err: got %b want 0000", in_err); end
        ack_off();
        checks++; if (unexp !== 1'b0) begin errors++; $display("FAIL t1_unexp: got %b want 0", unexp); end
    endtask

    task automatic test_round_robin();
        int          n;
        int          acc_p [5];
        int          acc_c [5];
        logic [15:0] acc_id [5];
        int          exp_p [5];
        logic [15:0] exp_id;
        exp_p = '{0, 1, 2, 3, 0};
        n = 0;
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 16'h0, 1'b1, 32'h1000 * p, 128'h0, 16'h0010 + 16'(p));
        out_accept = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (|in_accept && n < 5) begin
                for (int p = 0; p < NP; p++) if (in_accept[p]) acc_p[n] = p;
                acc_c[n]  = c;
                acc_id[n] = out_id;
                n++;
            end
        end
        tick();
        for (int p = 0; p < NP; p++) set_port(p, 16'h0, 1'b0, 32'h0, 128'h0, 16'h0);
        checks++; if (n != 5) begin errors++; $display("FAIL t2_accept_count: got %0d want 5", n); end
        for (int k = 0; k < 5; k++) begin
            if (k < n) begin
                exp_id = 16'((exp_p[k] << 14) | (16 + exp_p[k]));
                checks++; if (acc_p[k] != exp_p[k]) begin errors++; $display("FAIL t2_grant%0d: got %0d want %0d", k, acc_p[k], exp_p[k]); end
                checks++; if (acc_c[k] != 1 + 2 * k) begin errors++; $display("FAIL t2_cycle%0d: got %0d want %0d", k, acc_c[k], 1 + 2 * k); end
                checks++; if (acc_id[k] !== exp_id) begin errors++; $display("FAIL t2_id%0d: got %h want %h", k, acc_id[k], exp_id); end
            end
        end
        for (int k = 0; k < 5; k++) begin
            exp_id = 16'((exp_p[k] << 14) | (16 + exp_p[k]));
            ack_on(exp_id, (k == 2), 128'h0);
            checks++; if (in_ack !== 4'(1 << exp_p[k])) begin errors++; $display("FAIL t2_ack%0d: got %b want %b", k, in_ack, 4'(1 << exp_p[k])); end
            checks++; if (in_err !== ((k == 2) ? 4'(1 << exp_p[k]) : 4'b0)) begin errors++; $display("FAIL t2_err%0d: got %b", k, in_err); end
            checks++; if (in_resp_id[exp_p[k]*16 +: 16] !== 16'(16 + exp_p[k])) begin errors++; $display("FAIL t2_resp_id%0d: got %h want %h", k, in_resp_id[exp_p[k]*16 +: 16], 16'(16 + exp_p[k])); end
            ack_off();
        end
        checks++; if (unexp !== 1'b0) begin errors++; $display("FAIL t2_unexp: got %b want 0", unexp); end
    endtask

    task automatic test_outstanding_limit();
        logic ok;
        int   lat;
        int   oks;
        int   a [NP];
        oks = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_req(1, 16'h00FF, 1'b0, 32'h100 + 32'(k * 16), 128'h0, 16'h0020 + 16'(k), ok, lat);
            if (ok) oks++;
        end
        checks++; if (oks != 4) begin errors++; $display("FAIL t3_four_writes: got %0d want 4", oks); end
        set_port(1, 16'h00FF, 1'b0, 32'h200, 128'h0, 16'h0020);
        set_port(0, 16'h0, 1'b1, 32'h300, 128'h0, 16'h0030);
        set_port(2, 16'h0, 1'b1, 32'h400, 128'h0, 16'h0031);
        out_accept = 1'b1;
        for (int p = 0; p < NP; p++) a[p] = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            for (int p = 0; p < NP; p++) if (in_accept[p]) a[p]++;
        end
        set_port(0, 16'h0, 1'b0, 32'h0, 128'h0, 16'h0);
        set_port(2, 16'h0, 1'b0, 32'h0, 128'h0, 16'h0);
        checks++; if (a[1] != 0) begin errors++; $display("FAIL t3_port1_blocked: got %0d want 0", a[1]); end
        checks++; if (a[0] != 2) begin errors++; $display("FAIL t3_port0_served: got %0d want 2", a[0]); end
        checks++; if (a[2] != 3) begin errors++; $display("FAIL t3_port2_served: got %0d want 3", a[2]); end
        ack_on(16'h4020, 1'b0, 128'h0);
        checks++; if (in_ack !== 4'b0010) begin errors++; $display("FAIL t3_ack: got %b want 0010", in_ack); end
        ack_off();
        send_req(1, 16'h00FF, 1'b0, 32'h200, 128'h0, 16'h0024, ok, lat);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t3_freed: got %b want 1", ok); end
        checks++; if (lat != 1) begin errors++; $display("FAIL t3_freed_latency: got %0d want 1", lat); end
    endtask

    task automatic test_id_tagging();
        logic ok;
        int   lat;
        do_reset();
        send_req(2, 16'h0, 1'b1, 32'h40, 128'h0, 16'hC005, ok, lat);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t4_accept: got %b want 1", ok); end
        checks++; if (cap_id !== 16'h8005) begin errors++; $display("FAIL t4_out_id: got %h want 8005", cap_id); end
        checks++; if (cap_addr !== 32'h40) begin errors++; $display("FAIL t4_out_addr: got %h want 00000040", cap_addr); end
        ack_on(16'h8005, 1'b0, 128'h0);
        checks++; if (in_ack !== 4'b0100) begin errors++; $display("FAIL t4_ack: got %b want 0100", in_ack); end
        checks++; if (in_resp_id[32 +: 16] !== 16'h0005) begin errors++; $display("FAIL t4_resp_id: got %h want 0005", in_resp_id[32 +: 16]); end
        checks++; if (in_resp_id[0 +: 16] !== 16'h0) begin errors++; $display("FAIL t4_resp_id_other: got %h want 0000", in_resp_id[0 +: 16]); end
        ack_off();
        checks++; if (unexp !== 1'b0) begin errors++; $display("FAIL t4_unexp: got %b want 0", unexp); end
    endtask

    task automatic test_unexpected_ack();
        logic ok;
        int   lat;
        int   oks;
        oks = 0;
        do_reset();
        ack_on(16'hC123, 1'b0, 128'h0);
        checks++; if (in_ack !== 4'b1000) begin errors++; $display("FAIL t5_forward: got %b want 1000", in_ack); end
        checks++; if (in_resp_id[48 +: 16] !== 16'h0123) begin errors++; $display("FAIL t5_resp_id: got %h want 0123", in_resp_id[48 +: 16]); end
        ack_off();
        checks++; if (unexp !== 1'b1) begin errors++; $display("FAIL t5_unexp_set: got %b want 1", unexp); end
        for (int k = 0; k < 4; k++) begin
            send_req(3, 16'h0, 1'b1, 32'h500, 128'h0, 16'h0050 + 16'(k), ok, lat);
            if (ok) oks++;
        end
        checks++; if (oks != 4) begin errors++; $display("FAIL t5_cnt_zero: got %0d accepts want 4", oks); end
        send_req(3, 16'h0, 1'b1, 32'h500, 128'h0, 16'h0054, ok, lat);
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL t5_fifth_blocked: got %b want 0", ok); end
        checks++; if (unexp !== 1'b1) begin errors++; $display("FAIL t5_unexp_sticky: got %b want 1", unexp); end
    endtask

    task automatic test_reset_mid_op();
        logic ok;
        int   lat;
        int   oks;
        logic [NP-1:0] first;
        oks   = 0;
        first = '0;
        do_reset();
        send_req(1, 16'h0, 1'b1, 32'h10, 128'h0, 16'h0061, ok, lat);
        send_req(1, 16'h0, 1'b1, 32'h20, 128'h0, 16'h0062, ok, lat);
        set_port(2, 16'h0, 1'b1, 32'h30, 128'h0, 16'h0033);
        out_accept = 1'b0;
        tick();
        checks++; if (out_rd !== 1'b1 || out_id !== 16'h8033) begin errors++; $display("FAIL t6_hold: got rd=%b id=%h want 1 8033", out_rd, out_id); end
        #1;
        rst_n      = 1'b0;
        out_accept = 1'b1;
        #1;
        checks++; if (out_rd !== 1'b0 || out_id !== 16'h0) begin errors++; $display("FAIL t6_async_out: got rd=%b id=%h want 0 0000", out_rd, out_id); end
        checks++; if (in_accept !== 4'b0) begin errors++; $display("FAIL t6_async_accept: got %b want 0000", in_accept); end
        tick();
        tick();
        set_port(0, 16'h0, 1'b1, 32'h70, 128'h0, 16'h0070);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (|in_accept) begin
                first = in_accept;
                break;
            end
        end
        tick();
        set_port(0, 16'h0, 1'b0, 32'h0, 128'h0, 16'h0);
        set_port(2, 16'h0, 1'b0, 32'h0, 128'h0, 16'h0);
        checks++; if (first !== 4'b0001) begin errors++; $display("FAIL t6_first_grant: got %b want 0001", first); end
        for (int k = 0; k < 4; k++) begin
            send_req(1, 16'h0, 1'b1, 32'h80, 128'h0, 16'h0080 + 16'(k), ok, lat);
            if (ok) oks++;
        end
        checks++; if (oks != 4) begin errors++; $display("FAIL t6_counts_cleared: got %0d accepts want 4", oks); end
    endtask

    initial begin
        test_reset();
        test_port0_rw();
        test_round_robin();
        test_outstanding_limit();
        test_id_tagging();
        test_unexpected_ack();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
